uart_fifo_wb: RTL and testbench

Buffered Wishbone UART, the next-generation serial console peripheral for the firmware payload. Parametrised TX/RX FIFOs, optional parity, 1 or 2 stop bits, sticky error flags, a status register and a level-sensitive interrupt. It replaces the unbuffered UART on the same Wishbone slave port. DIV/DATA/CONFIG offsets are unchanged, so existing firmware keeps working.

---
 rtl/uart_fifo_wb.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_wb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_wb.sv
// Buffered Wishbone UART: TX/RX byte FIFOs, optional parity, 1/2 stop bits,
// sticky error flags and a level interrupt on a single-cycle-ack slave port.

module uart_fifo_wb_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          ovf
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        pop_ok, push_ok;

    assign level   = wptr - rptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rptr[AW-1:0]];
    assign pop_ok  = pop & ~empty;
    // a pop on the same edge frees the slot the push needs
    assign push_ok = push & (~full | pop_ok);
    assign ovf     = push & ~push_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

module uart_fifo_wb #(
    parameter logic [31:0] BASE_ADR   = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] DIV_RESET  = 32'd1
) (
    input  logic        wb_clk_i,
    input  logic        resetn,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        irq,
    output logic        uart_enabled,
    output logic        ser_tx,
    input  logic        ser_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic err_ie;
        logic tx_ie;
        logic rx_ie;
        logic stop2;
        logic parity_odd;
        logic parity_en;
        logic enable;
    } cfg_t;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [31:0] div;
    cfg_t        cfg;
    logic [3:0]  sticky;   // {tx_ovf, parity_err, frame_err, rx_ovr}

    logic sel_div, sel_data, sel_cfg, sel_stat, hit, acc, wr, rd;
    assign sel_div  = (wb_adr_i == BASE_ADR);
    assign sel_data = (wb_adr_i == BASE_ADR + 32'h4);
    assign sel_cfg  = (wb_adr_i == BASE_ADR + 32'h8);
    assign sel_stat = (wb_adr_i == BASE_ADR + 32'hC);
    assign hit      = wb_cyc_i & wb_stb_i & (sel_div | sel_data | sel_cfg | sel_stat);
    assign acc      = hit & ~wb_ack_o;
    assign wr       = acc & wb_we_i;
    assign rd       = acc & ~wb_we_i;

    logic [31:0] div_eff, half;
    assign div_eff = (div == '0) ? 32'd1 : div;
    assign half    = 32'((33'(div_eff) + 33'd1) >> 1);

    // FIFOs
    logic        tx_push, tx_pop, tx_full, tx_empty, tx_ovf_evt;
    logic [7:0]  tx_dout;
    logic [AW:0] tx_level;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_ovr_evt;
    logic [7:0]  rx_dout, rx_shift;
    logic [AW:0] rx_level;

    assign tx_push = wr & sel_data & wb_sel_i[0];
    assign rx_pop  = rd & sel_data;

    uart_fifo_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .resetn(resetn), .push(tx_push), .wdata(wb_dat_i[7:0]),
        .pop(tx_pop), .rdata(tx_dout), .level(tx_level), .full(tx_full),
        .empty(tx_empty), .ovf(tx_ovf_evt)
    );

    uart_fifo_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .resetn(resetn), .push(rx_push), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_dout), .level(rx_level), .full(rx_full),
        .empty(rx_empty), .ovf(rx_ovr_evt)
    );

    // Register file and bus
    logic [31:0] status, rdata;
    logic        rx_par_evt, rx_frm_evt;
    logic [3:0]  sticky_clr;

    assign status = {8'h0, 8'(tx_level), 8'(rx_level), sticky,
                     rx_full, ~rx_empty, tx_full, tx_empty};
    assign sticky_clr = (wr & sel_stat & wb_sel_i[0]) ? wb_dat_i[7:4] : 4'h0;

    always_comb begin
        rdata = '0;
        if (sel_div)       rdata = div;
        else if (sel_data) rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_dout};
        else if (sel_cfg)  rdata = {25'h0, cfg};
        else if (sel_stat) rdata = status;
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            div      <= DIV_RESET;
            cfg      <= '0;
            sticky   <= '0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= rd ? rdata : '0;
            if (wr & sel_div) begin
                for (int i = 0; i < 4; i++)
                    if (wb_sel_i[i]) div[8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
            if (wr & sel_cfg & wb_sel_i[0]) cfg <= cfg_t'(wb_dat_i[6:0]);
            sticky <= (sticky & ~sticky_clr) | {tx_ovf_evt, rx_par_evt, rx_frm_evt, rx_ovr_evt};
        end
    end

    assign uart_enabled = cfg.enable;
    assign irq = (cfg.rx_ie & ~rx_empty) | (cfg.tx_ie & tx_empty) | (cfg.err_ie & |sticky);

    // TX FSM
    tx_state_t   tx_state, tx_state_n;
    logic [31:0] tx_cnt;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_par, tx_par_n, tx_line_n, tx_tick, tx_frame_end;

    assign tx_tick = (tx_cnt == div_eff);

    always_comb begin
        tx_state_n   = tx_state;
        tx_bit_n     = tx_bit;
        tx_shift_n   = tx_shift;
        tx_par_n     = tx_par;
        tx_line_n    = ser_tx;
        tx_pop       = 1'b0;
        tx_frame_end = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_frame_end = 1'b1;
            TX_START:  if (tx_tick) begin
                           tx_state_n = TX_DATA;
                           tx_bit_n   = 3'd0;
                           tx_line_n  = tx_shift[0];
                       end
            TX_DATA:   if (tx_tick) begin
                           if (tx_bit == 3'd7) begin
                               tx_state_n = cfg.parity_en ? TX_PARITY : TX_STOP1;
                               tx_line_n  = cfg.parity_en ? tx_par : 1'b1;
                           end else begin
                               tx_bit_n   = tx_bit + 3'd1;
                               tx_shift_n = tx_shift >> 1;
                               tx_line_n  = tx_shift[1];
                           end
                       end
            TX_PARITY: if (tx_tick) begin
                           tx_state_n = TX_STOP1;
                           tx_line_n  = 1'b1;
                       end
            TX_STOP1:  if (tx_tick) begin
                           if (cfg.stop2) tx_state_n = TX_STOP2;
                           else           tx_frame_end = 1'b1;
                       end
            TX_STOP2:  tx_frame_end = tx_tick;
            default:   tx_state_n = TX_IDLE;
        endcase
        // the next start bit follows the last stop bit with no idle gap
        if (tx_frame_end) begin
            if (cfg.enable & ~tx_empty) begin
                tx_state_n = TX_START;
                tx_pop     = 1'b1;
                tx_shift_n = tx_dout;
                tx_par_n   = ^tx_dout ^ cfg.parity_odd;
                tx_line_n  = 1'b0;
            end else begin
                tx_state_n = TX_IDLE;
                tx_line_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            ser_tx   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 32'd1;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            ser_tx   <= tx_line_n;
        end
    end

    // RX FSM
    rx_state_t   rx_state, rx_state_n;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift_n;
    logic        rx_s1, rx_s2, rx_tick;

    // start bit is checked at mid-bit, every later sample one full period on
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == half - 32'd1) : (rx_cnt == div_eff);

    always_comb begin
        rx_state_n = rx_state;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_par_evt = 1'b0;
        rx_frm_evt = 1'b0;
        if (!cfg.enable) begin
            rx_state_n = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (!rx_s2) rx_state_n = RX_START;
                RX_START:  if (rx_tick) begin
                               rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                               rx_bit_n   = 3'd0;
                           end
                RX_DATA:   if (rx_tick) begin
                               rx_shift_n = {rx_s2, rx_shift[7:1]};
                               rx_bit_n   = rx_bit + 3'd1;
                               if (rx_bit == 3'd7)
                                   rx_state_n = cfg.parity_en ? RX_PARITY : RX_STOP;
                           end
                RX_PARITY: if (rx_tick) begin
                               rx_par_evt = rx_s2 ^ (^rx_shift) ^ cfg.parity_odd;
                               rx_state_n = RX_STOP;
                           end
                RX_STOP:   if (rx_tick) begin
                               rx_push    = 1'b1;
                               rx_frm_evt = ~rx_s2;
                               rx_state_n = RX_IDLE;
                           end
                default:   rx_state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge resetn) begin
        if (!resetn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= ser_rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 32'd1;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// Self-checking bench for uart_fifo_wb: register vector table, directed
// serial corner cases and randomized loopback against a queue model.

module tb_uart_fifo_wb;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0, resetn = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        rx_drv = 1'b1, loop = 1'b0;
    logic        ack, irq, uen, ser_tx, ser_rx;
    logic [31:0] dout;

    assign ser_rx = loop ? ser_tx : rx_drv;

    uart_fifo_wb #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(32'd1)) dut (
        .wb_clk_i(clk), .resetn(resetn), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_ack_o(ack), .wb_dat_o(dout), .irq(irq), .uart_enabled(uen),
        .ser_tx(ser_tx), .ser_rx(ser_rx)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // expected STATUS word from levels and sticky nibble {tx_ovf,par,frm,ovr}
    function automatic logic [31:0] st(input int txl, input int rxl, input logic [3:0] stk);
        logic [7:0] t, r;
        t = 8'(txl);
        r = 8'(rxl);
        return {8'h0, t, r, stk, rxl == DEPTH, rxl != 0, txl == DEPTH, txl == 0};
    endfunction

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic got_ack, output logic [31:0] r);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        got_ack = 1'b0;
        r = '0;
        for (int i = 0; i < 4 && !got_ack; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got_ack = 1'b1;
                r = dout;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s = 4'h1);
        logic a;
        logic [31:0] r;
        bus(BASE + off, 1'b1, d, s, a, r);
        chk($sformatf("write ack @%0h", off), {31'h0, a}, 32'h1);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] r);
        logic a;
        bus(BASE + off, 1'b0, 32'h0, 4'hF, a, r);
        chk($sformatf("read ack @%0h", off), {31'h0, a}, 32'h1);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] r;
        rd(off, r);
        chk(nm, r, exp);
    endtask

    // Called 1ns after the edge where the start bit should begin; samples each
    // bit mid-period and returns 1ns after the edge where the frame ends.
    task automatic check_frame(input logic [7:0] b, input int per, input bit pe,
                               input bit po, input bit s2, input string nm);
        logic [11:0] exp, got;
        int nb;
        exp = '0; got = '0;
        exp[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp[1+i] = b[i];
        nb = 9;
        if (pe) begin exp[nb] = ^b ^ po; nb++; end
        exp[nb] = 1'b1; nb++;
        if (s2) begin exp[nb] = 1'b1; nb++; end
        for (int i = 0; i < nb; i++) begin
            repeat (per / 2) @(posedge clk);
            #1;
            got[i] = ser_tx;
            repeat (per - per / 2) @(posedge clk);
            #1;
        end
        chk(nm, {20'h0, got}, {20'h0, exp});
    endtask

    task automatic bit_out(input logic v, input int per);
        rx_drv = v;
        repeat (per) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input bit pe,
                              input bit pbit, input bit stopv);
        bit_out(1'b0, per);
        for (int i = 0; i < 8; i++) bit_out(b[i], per);
        if (pe) bit_out(pbit, per);
        bit_out(stopv, per);
        bit_out(1'b1, 2 * per);
    endtask

    typedef struct {
        logic [31:0] off;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
        logic        ack;
        logic [31:0] rdat;
        logic        irq;
    } vec_t;

    vec_t        vt[16];
    logic [7:0]  q[$];
    logic [31:0] r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{32'h0,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0001, 1'b0};
        vt[1]  = '{32'h8,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0000, 1'b0};
        vt[2]  = '{32'hC,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0001, 1'b0};
        vt[3]  = '{32'h4,  1'b0, 32'h0,         4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vt[4]  = '{32'h10, 1'b0, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0};
        vt[5]  = '{32'h0,  1'b1, 32'h1234_5678, 4'h3, 1'b1, 32'h0,         1'b0};
        vt[6]  = '{32'h0,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_5678, 1'b0};
        vt[7]  = '{32'h0,  1'b1, 32'hAABB_CCDD, 4'hC, 1'b1, 32'h0,         1'b0};
        vt[8]  = '{32'h0,  1'b0, 32'h0,         4'hF, 1'b1, 32'hAABB_5678, 1'b0};
        vt[9]  = '{32'h8,  1'b1, 32'hFFFF_FFF0, 4'h1, 1'b1, 32'h0,         1'b1};
        vt[10] = '{32'h8,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0070, 1'b1};
        vt[11] = '{32'h8,  1'b1, 32'h0000_0001, 4'h2, 1'b1, 32'h0,         1'b1};
        vt[12] = '{32'h8,  1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0070, 1'b1};
        vt[13] = '{32'h8,  1'b1, 32'h0,         4'h1, 1'b1, 32'h0,         1'b0};
        vt[14] = '{32'h2,  1'b0, 32'h0,         4'hF, 1'b0, 32'h0,         1'b0};
        vt[15] = '{32'hC,  1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", {31'h0, ack}, 32'h0);
        chk("reset dat", dout, 32'h0);
        chk("reset irq", {31'h0, irq}, 32'h0);
        chk("reset ser_tx", {31'h0, ser_tx}, 32'h1);
        chk("reset uart_enabled", {31'h0, uen}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // register vector table
        for (int i = 0; i < 16; i++) begin
            logic a;
            logic [31:0] rv;
            bus(BASE + vt[i].off, vt[i].w, vt[i].d, vt[i].s, a, rv);
            chk($sformatf("vec%0d ack", i), {31'h0, a}, {31'h0, vt[i].ack});
            if (!vt[i].w && vt[i].ack) chk($sformatf("vec%0d rdata", i), rv, vt[i].rdat);
            chk($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vt[i].irq});
        end

        // loopback, DIV=3: start bit exactly one clock after the ack edge
        loop = 1'b1;
        wr(32'h0, 32'd3, 4'hF);
        wr(32'h8, 32'h1);
        wr(32'h4, 32'hA5);
        chk("tx idle at ack edge", {31'h0, ser_tx}, 32'h1);
        @(posedge clk);
        #1;
        chk("tx start E+1", {31'h0, ser_tx}, 32'h0);
        check_frame(8'hA5, 4, 0, 0, 0, "loopback frame A5");
        repeat (8) @(posedge clk);
        #1;
        rd_chk("loopback status", 32'hC, st(0, 1, 4'h0));
        rd_chk("loopback data", 32'h4, 32'h0000_00A5);
        rd_chk("loopback status after pop", 32'hC, st(0, 0, 4'h0));
        wr(32'h8, 32'h0);
        loop = 1'b0;

        // TX overflow with enable off, W1C, then drain in order
        wr(32'h0, 32'd1, 4'hF);
        q.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(b);
            wr(32'h4, {24'h0, b});
        end
        rd_chk("tx full status", 32'hC, st(DEPTH, 0, 4'b1000));
        wr(32'hC, 32'h80);
        rd_chk("tx_ovf cleared", 32'hC, st(DEPTH, 0, 4'b0000));
        wr(32'h8, 32'h1);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++)
            check_frame(q[i], 2, 0, 0, 0, $sformatf("tx drain byte %0d", i));
        chk("tx idle after drain", {31'h0, ser_tx}, 32'h1);
        rd_chk("tx drained status", 32'hC, st(0, 0, 4'h0));
        wr(32'h8, 32'h0);

        // RX overrun: DEPTH+1 frames, first DEPTH retained
        wr(32'h0, 32'd3, 4'hF);
        wr(32'h8, 32'h1);
        q.delete();
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(b);
            send_frame(b, 4, 0, 0, 1);
        end
        rd_chk("rx overrun status", 32'hC, st(0, DEPTH, 4'b0001));
        for (int i = 0; i < DEPTH; i++)
            rd_chk($sformatf("rx byte %0d", i), 32'h4, {24'h0, q[i]});
        rd_chk("rx empty read", 32'h4, 32'hFFFF_FFFF);
        wr(32'hC, 32'h10);
        rd_chk("rx_ovr cleared", 32'hC, st(0, 0, 4'h0));

        // parity error, then frame error; irq gated by err_ie
        wr(32'h0, 32'd7, 4'hF);
        wr(32'h8, 32'h7);
        send_frame(8'h01, 8, 1, 1'b1, 1'b1);
        send_frame(8'h3C, 8, 1, 1'b1, 1'b0);
        rd_chk("err status", 32'hC, st(0, 2, 4'b0110));
        chk("irq err_ie=0", {31'h0, irq}, 32'h0);
        wr(32'h8, 32'h47);
        chk("irq err_ie=1", {31'h0, irq}, 32'h1);
        rd_chk("parity-err byte", 32'h4, 32'h01);
        rd_chk("frame-err byte", 32'h4, 32'h3C);
        wr(32'hC, 32'h60);
        chk("irq after W1C", {31'h0, irq}, 32'h0);
        rd_chk("err cleared", 32'hC, st(0, 0, 4'h0));

        // 1-clock glitch at DIV=7 is rejected, next frame still received
        wr(32'h8, 32'h1);
        rx_drv = 1'b0;
        @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rd_chk("glitch no byte", 32'hC, st(0, 0, 4'h0));
        send_frame(8'h5A, 8, 0, 0, 1);
        rd_chk("after glitch byte", 32'h4, 32'h5A);
        wr(32'h8, 32'h0);

        // stop2 + tx_ie: 11-bit frames back to back, irq follows last pop
        wr(32'h0, 32'd1, 4'hF);
        wr(32'h8, 32'h28);
        chk("irq tx empty", {31'h0, irq}, 32'h1);
        wr(32'h4, 32'h3C);
        wr(32'h4, 32'hC3);
        chk("irq tx pending", {31'h0, irq}, 32'h0);
        wr(32'h8, 32'h29);
        @(posedge clk);
        #1;
        chk("irq during frame 1", {31'h0, irq}, 32'h0);
        check_frame(8'h3C, 2, 0, 0, 1, "stop2 frame 1");
        chk("irq at last pop", {31'h0, irq}, 32'h1);
        check_frame(8'hC3, 2, 0, 0, 1, "stop2 frame 2");
        repeat (2) @(posedge clk);
        #1;
        chk("stop2 line idle", {31'h0, ser_tx}, 32'h1);
        wr(32'h8, 32'h0);

        // randomized loopback against queue model
        loop = 1'b1;
        for (int it = 0; it < 3; it++) begin
            int dv, per, n;
            bit pe, po, s2;
            dv  = $urandom_range(0, 5);
            per = ((dv == 0) ? 1 : dv) + 1;
            pe  = 1'($urandom);
            po  = 1'($urandom);
            s2  = 1'($urandom);
            n   = $urandom_range(1, 8);
            wr(32'h0, 32'(dv), 4'hF);
            wr(32'h8, {28'h0, s2, po, pe, 1'b0});
            q.delete();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                q.push_back(b);
                wr(32'h4, {24'h0, b});
            end
            wr(32'h8, {28'h0, s2, po, pe, 1'b1});
            @(posedge clk);
            #1;
            for (int i = 0; i < n; i++)
                check_frame(q[i], per, pe, po, s2, $sformatf("rand%0d frame %0d", it, i));
            repeat (3 * per + 2) @(posedge clk);
            #1;
            rd_chk($sformatf("rand%0d status", it), 32'hC, st(0, n, 4'h0));
            for (int i = 0; i < n; i++)
                rd_chk($sformatf("rand%0d rx %0d", it, i), 32'h4, {24'h0, q[i]});
            wr(32'h8, 32'h0);
        end
        loop = 1'b0;

        // asynchronous reset mid-frame
        wr(32'h0, 32'd3, 4'hF);
        wr(32'h8, 32'h1);
        wr(32'h4, 32'h00);
        repeat (6) @(posedge clk);
        #2;
        chk("tx low before reset", {31'h0, ser_tx}, 32'h0);
        resetn = 1'b0;
        #1;
        chk("ser_tx async reset", {31'h0, ser_tx}, 32'h1);
        chk("uart_enabled async reset", {31'h0, uen}, 32'h0);
        chk("irq async reset", {31'h0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        rd_chk("status after reset", 32'hC, st(0, 0, 4'h0));
        rd_chk("config after reset", 32'h8, 32'h0);
        rd_chk("div after reset", 32'h0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
